// File: rtl/jserialtx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// One word is accepted per frame through a valid/ready handshake.
module jserialtx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             valid,
    output logic             ready,
    output logic             txd,
    output logic             done,
    output logic [2:0]       dbg_state
);

    // Handshake: a word is accepted at a rising edge where valid && ready;
    // ready is high only in IDLE, and valid is ignored at every other time.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PREV = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shreg;
    logic             par;

    logic             bit_end;
    logic             last_data;
    logic             enter_stop;
    logic             done_next;
    logic [WIDTH-1:0] shreg_nxt;

    always_comb begin
        bit_end    = (cnt == CNT_LAST);
        last_data  = (idx == IDX_LAST);
        shreg_nxt  = shreg >> 1;
        enter_stop = bit_end && (((state == DATA) && last_data && (PARITY_EN == 0)) ||
                                 (state == PARITY));
        // done is registered, so it is raised on the edge that starts the last stop cycle.
        if (CLKS_PER_BIT == 1) begin
            done_next = enter_stop;
        end else begin
            done_next = (state == STOP) && (cnt == CNT_PREV);
        end
    end

    assign ready     = (state == IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            txd   <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= done_next;
            if (state != IDLE) begin
                cnt <= bit_end ? '0 : cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (valid) begin
                        shreg <= din;
                        par   <= (^din) ^ ODD_BIT;
                        cnt   <= '0;
                        idx   <= '0;
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (last_data) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                txd   <= par;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            idx   <= idx + IW'(1);
                            shreg <= shreg_nxt;
                            txd   <= shreg_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jserialtx.sv
// Bench for jserialtx: four parameter variants, table vectors, random words, and
// hand-written back-to-back, busy-valid and mid-frame reset sequences.
module tb_jserialtx;

    logic       clk;
    logic       rst;
    logic [7:0] din   [4];
    logic       valid [4];
    logic       txd   [4];
    logic       ready [4];
    logic       done  [4];
    logic [2:0] dbg   [4];

    int n_checks = 0;
    int n_errors = 0;

    // Variant table: 0 = even parity, 1 = odd parity, 2 = no parity, 3 = one clock per bit.
    int cpb_of  [4] = '{4, 4, 4, 1};
    int pen_of  [4] = '{1, 1, 0, 1};
    int podd_of [4] = '{0, 1, 0, 0};

    jserialtx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .din(din[0]), .valid(valid[0]), .ready(ready[0]),
        .txd(txd[0]), .done(done[0]), .dbg_state(dbg[0]));
    jserialtx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst(rst), .din(din[1]), .valid(valid[1]), .ready(ready[1]),
        .txd(txd[1]), .done(done[1]), .dbg_state(dbg[1]));
    jserialtx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u2 (
        .clk(clk), .rst(rst), .din(din[2]), .valid(valid[2]), .ready(ready[2]),
        .txd(txd[2]), .done(done[2]), .dbg_state(dbg[2]));
    jserialtx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u3 (
        .clk(clk), .rst(rst), .din(din[3]), .valid(valid[3]), .ready(ready[3]),
        .txd(txd[3]), .done(done[3]), .dbg_state(dbg[3]));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Reference: the frame as a list of bit slots, each lasting cpb clocks.
    function automatic int frame_len(input int k);
        return (2 + 8 + pen_of[k]) * cpb_of[k];
    endfunction

    function automatic logic model_bit(input int k, input logic [7:0] w, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return w[slot-1];
        if (pen_of[k] != 0 && slot == 9) return logic'(($countones(w) % 2) != podd_of[k]);
        return 1'b1;
    endfunction

    task automatic check_idle(input string name, input int k);
        chk({name, "_txd"}, k, 32'(txd[k]), 32'd1);
        chk({name, "_ready"}, k, 32'(ready[k]), 32'd1);
        chk({name, "_done"}, k, 32'(done[k]), 32'd0);
    endtask

    // Drivers
    task automatic start_frame(input int k, input logic [7:0] w);
        @(negedge clk);
        din[k]   = w;
        valid[k] = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accept edge; checks every cycle of the frame and the idle cycle after.
    task automatic check_frame(input int k, input logic [7:0] w, input logic [7:0] mid_din,
                               input bit mid_valid, input bit hold, input int stop_at,
                               output int done_at, output logic par_seen);
        int f;
        int last;
        f        = frame_len(k);
        last     = (stop_at > 0) ? stop_at : f;
        done_at  = -1;
        par_seen = 1'bx;
        for (int c = 1; c <= last; c++) begin
            int slot;
            @(negedge clk);
            slot = (c - 1) / cpb_of[k];
            chk("frame_txd", k, 32'(txd[k]), 32'(model_bit(k, w, slot)));
            chk("frame_ready", k, 32'(ready[k]), 32'd0);
            chk("frame_done", k, 32'(done[k]), 32'(c == f));
            if (done[k] === 1'b1 && done_at < 0) done_at = c;
            if (pen_of[k] != 0 && slot == 9) par_seen = txd[k];
            if (c == 1) begin
                din[k]   = mid_din;
                valid[k] = mid_valid;
            end
            if (c == 2) valid[k] = hold;
        end
        if (stop_at == 0) begin
            @(negedge clk);
            check_idle("after_frame", k);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] word;
        int         exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int         dat;
        logic       ps;

        vecs[0] = '{k: 0, word: 8'hA5, exp_par: 0,  exp_len: 44};
        vecs[1] = '{k: 0, word: 8'h07, exp_par: 1,  exp_len: 44};
        vecs[2] = '{k: 1, word: 8'h07, exp_par: 0,  exp_len: 44};
        vecs[3] = '{k: 2, word: 8'h07, exp_par: -1, exp_len: 40};
        vecs[4] = '{k: 3, word: 8'h01, exp_par: 1,  exp_len: 11};

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[i]   = 8'h00;
            valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) check_idle("reset", i);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors
        foreach (vecs[i]) begin
            start_frame(vecs[i].k, vecs[i].word);
            check_frame(vecs[i].k, vecs[i].word, 8'($urandom), 1'b0, 1'b0, 0, dat, ps);
            chk("vec_len", vecs[i].k, 32'(dat), 32'(vecs[i].exp_len));
            if (vecs[i].exp_par >= 0) chk("vec_par", vecs[i].k, 32'(ps), 32'(vecs[i].exp_par));
        end

        // Back-to-back with valid held; din changes mid-frame in both frames
        start_frame(0, 8'h3C);
        check_frame(0, 8'h3C, 8'hC3, 1'b1, 1'b1, 0, dat, ps);
        @(posedge clk);
        check_frame(0, 8'hC3, 8'hFF, 1'b0, 1'b0, 0, dat, ps);
        chk("b2b_len", 0, 32'(dat), 32'd44);

        // valid pulsed while busy is ignored; no second frame follows
        start_frame(0, 8'h5A);
        check_frame(0, 8'h5A, 8'hFF, 1'b1, 1'b0, 0, dat, ps);
        repeat (8) begin
            @(negedge clk);
            check_idle("busy_ignore", 0);
        end

        // Asynchronous reset in the middle of the data bits
        start_frame(0, 8'h55);
        check_frame(0, 8'h55, 8'h55, 1'b0, 1'b0, 20, dat, ps);
        #2;
        rst = 1'b0;
        #1;
        check_idle("async_reset", 0);
        @(negedge clk);
        check_idle("in_reset", 0);
        din[0]   = 8'h81;
        valid[0] = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        check_frame(0, 8'h81, 8'h00, 1'b0, 1'b0, 0, dat, ps);
        chk("post_reset_len", 0, 32'(dat), 32'(frame_len(0)));

        // Random words on random variants
        for (int n = 0; n < 24; n++) begin
            int         k;
            logic [7:0] w;
            k = $urandom_range(0, 3);
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_frame(k, w);
            check_frame(k, w, 8'($urandom), 1'($urandom), 1'b0, 0, dat, ps);
            chk("rand_len", k, 32'(dat), 32'(frame_len(k)));
            repeat (2) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jserialtx.md
# jserialtx

Parameterised serial transmitter that frames a parallel word into a single-wire bit stream: start bit, data LSB first, optional parity, stop bit. It is the driving end of the lab's serial link: downstream D-flip-flop capture stages and receivers sample `txd` once per bit period. A valid/ready handshake on the parallel side accepts one word per frame. All outputs are registered or decoded from state.

## Interface
- `WIDTH`, 8: data bits per frame (≥1).
- `CLKS_PER_BIT`, 4: clock cycles per serial bit (≥1).
- `PARITY_EN`, 1: 1 = parity bit inserted after data; 0 = no parity bit.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity (ignored when `PARITY_EN`=0).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  word to transmit; sampled only on the accept edge.
- `valid`  in  1  word on `din` is offered.
- `ready`  out  1  high when IDLE; accept = `valid && ready` at a rising edge.
- `txd`  out  1  serial output, registered; idle level 1.
- `done`  out  1  one-cycle pulse on the final cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `txd`=1, `ready`=1.
  - On accept: load the shift register with `din`, compute the parity bit, clear the bit-period counter and bit index, go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `txd` = shift-register bit 0; after each `CLKS_PER_BIT` cycles shift right and increment the bit index.
  - After WIDTH bits go to PARITY if `PARITY_EN`, else STOP.
- PARITY:
  - `txd` = XOR of the captured word, inverted when `PARITY_ODD`.
  - Held `CLKS_PER_BIT` cycles, then go to STOP.
- STOP:
  - `txd`=1 for `CLKS_PER_BIT` cycles.
  - `done`=1 during the last of those cycles, then go to IDLE.
- `ready` = (state == IDLE), decoded from state.
- `valid` while not IDLE is ignored: no queueing, no error.
- `din` changes after the accept edge have no effect on the current frame.
- Bit-period counter is ⌈log2(CLKS_PER_BIT)⌉ bits wide (minimum 1) and wraps to 0 at `CLKS_PER_BIT`-1.
- Bit index counts 0..WIDTH-1.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE, `txd`=1, `ready`=1, `done`=0.
  - Counters and shift register cleared.
  - Takes effect immediately, mid-frame included; the partial frame is abandoned with no `done`.
- Frame timing:
  - Let edge E0 be the accept edge. `txd` falls to 0 in the cycle after E0.
  - Frame length F = (2 + WIDTH + PARITY_EN) × `CLKS_PER_BIT` clocks.
  - `ready` is low for exactly F cycles after E0 and returns high the cycle after the `done` pulse.
- Back-to-back: with `valid` held high, the next accept occurs on the first edge with `ready`=1. This gives exactly one idle cycle of `txd`=1 between stop bit and next start bit, so the word period is F+1 clocks.
- Release of reset with `valid`=1: accept on the first rising edge after release.
- `CLKS_PER_BIT`=1: one bit per clock, with no other change in behaviour.

## Test plan
- Reset, then `din`=8'hA5, `valid` for 1 cycle (`CLKS_PER_BIT`=4, even parity) -> `txd` sequence per 4-clock bit is 0,1,0,1,0,0,1,0,1,0(parity),1; `done` pulses at clock 44 after accept; `ready` high again at clock 45.
- `din`=8'h07, even parity -> data bits 1,1,1,0,0,0,0,0 and parity bit 1. Same word with `PARITY_ODD`=1 -> parity bit 0. With `PARITY_EN`=0 -> frame is 40 clocks and no parity bit.
- `valid` held high with `din`=8'h3C then 8'hC3 -> two complete frames, separated by exactly 1 idle clock at `txd`=1. The second frame carries 8'hC3 despite `din` changing mid-frame.
- `valid` pulsed with `din`=8'hFF while busy -> ignored; the current frame completes unchanged and no second frame starts.
- Assert `rst`=0 mid-DATA of an 8'h55 frame -> `txd`=1, `ready`=1, `done`=0 immediately, before the next clock edge. After release, a new 8'h81 frame transmits correctly.
- `CLKS_PER_BIT`=1, `din`=8'h01 -> 11-clock frame 0,1,0,0,0,0,0,0,0,1,1; `done` on the 11th cycle.
